pc_sequencer: RTL
=================

Name: pc_sequencer

Overview:
Parametrised program counter for the pipeline fetch stage. It extends a plain incrementing counter with configurable width, reset vector and step. It adds stall, absolute jump, conditional PC-relative branch, and call/return through an internal return-address stack of configurable depth. Its output feeds instruction-memory addressing directly.

Parameters:
PC_WIDTH, 8, width of pc, target and offset in bits (>=2)
RESET_VECTOR, 0, value loaded into pc on reset (truncated to PC_WIDTH)
STEP, 1, sequential increment per advance (1..2^PC_WIDTH-1)
STACK_DEPTH, 4, return-address stack entries (>=1)

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous active-high reset
en  input  1  advance enable; 0 = stall, all state held
op  input  3  000 SEQ, 001 JUMP, 010 BRANCH, 011 CALL, 100 RET; 101-111 treated as SEQ
cond  input  1  branch condition, sampled only for BRANCH
target  input  PC_WIDTH  absolute destination for JUMP/CALL
offset  input  PC_WIDTH  two's-complement signed displacement for BRANCH
pc  output  PC_WIDTH  current program counter (registered)
depth  output  $clog2(STACK_DEPTH+1)  number of valid stack entries
stack_full  output  1  depth == STACK_DEPTH (combinational from depth)
stack_empty  output  1  depth == 0 (combinational from depth)
ovf_err  output  1  sticky: CALL attempted while full
unf_err  output  1  sticky: RET attempted while empty

Behaviour:
- Reset is synchronous and active-high. On a rising edge with rst=1: pc=RESET_VECTOR, depth=0, ovf_err=0, unf_err=0. Stack contents are don't-care. rst overrides en and op.
- Priority per edge: rst > (en=0 hold) > op decode.
- en=0: pc, depth, stack and error flags unchanged; op, cond, target and offset are ignored.
- Latency: the new pc is visible on the output the cycle after the edge that samples the op. No combinational path from any input to pc.
- Arithmetic: all pc sums are modulo 2^PC_WIDTH and wrap silently. Example: PC_WIDTH=8, pc=0xFF, SEQ -> 0x00. No carry or error output.
- SEQ: pc <= pc+STEP.
- JUMP: pc <= target.
- BRANCH: cond=1 -> pc <= pc+offset, with offset treated as signed (0xFE = -2). cond=0 -> pc <= pc+STEP.
- CALL, not full: stack[depth] <= pc+STEP; depth <= depth+1; pc <= target.
- CALL, full: pc <= target (the jump is still taken); push discarded; depth and stack unchanged; ovf_err <= 1.
- RET, not empty: pc <= stack[depth-1]; depth <= depth-1.
- RET, empty: pc <= pc+STEP; depth stays 0; unf_err <= 1.
- The stack is LIFO and indexed by depth. No simultaneous push and pop is possible, since there is one op per cycle.
- Error flags are sticky and cleared only by rst.
- Reset mid-sequence (stack non-empty, or during a stall) discards all return addresses. The next edge after rst deasserts starts from RESET_VECTOR.
- Illegal op codes 101-111 behave exactly as SEQ and set no flag.

Test Plan:
- Reset and sequencing: PC_WIDTH=8, RESET_VECTOR=0x10, STEP=1. Hold rst 2 cycles, then en=1 with SEQ for 3 cycles -> pc 0x10, 0x11, 0x12, 0x13. depth=0, stack_empty=1, both errors 0.
- Stall and wrap: set pc=0xFE via JUMP, then SEQ,SEQ,SEQ with en pulsed 1,0,1 -> pc 0xFF, 0xFF (held), 0x00. With STEP=4 from 0xFE -> 0x02.
- Branch: pc=0x20; BRANCH offset=0xFE, cond=1 -> 0x1E. BRANCH offset=0x05, cond=0 -> 0x1F. BRANCH offset=0x80, cond=1 from 0x1F -> 0x9F.
- Nested call/return: STACK_DEPTH=4, pc=0x00. CALL 0x40, CALL 0x60, RET, RET -> pc 0x40, 0x60, 0x41, 0x01. depth goes 1, 2, 1, 0.
- Overflow/underflow: 5 consecutive CALLs to 0x80 from pc=0x00 -> 5th jumps to 0x80, depth stays 4, stack_full=1, ovf_err=1. Then 5 RETs -> 4 pops return 0x81, 0x81, 0x81, 0x01, 5th gives pc=0x02, unf_err=1, ovf_err still 1.
- Reset mid-operation: depth=3, assert rst for 1 cycle with op=RET and en=1 -> pc=RESET_VECTOR, depth=0, errors 0. The following RET sets unf_err=1.

Source files
------------

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - fetch-stage program counter with stall, jump, branch and call/return stack
// Handles SEQ/JUMP/BRANCH/CALL/RET; sticky flags record push-when-full and pop-when-empty.
module pc_sequencer #(
  parameter int PC_WIDTH     = 8,
  parameter int RESET_VECTOR = 0,
  parameter int STEP         = 1,
  parameter int STACK_DEPTH  = 4,
  localparam int DW          = $clog2(STACK_DEPTH + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [2:0]          op,
  input  logic                cond,
  input  logic [PC_WIDTH-1:0] target,
  input  logic [PC_WIDTH-1:0] offset,
  output logic [PC_WIDTH-1:0] pc,
  output logic [DW-1:0]       depth,
  output logic                stack_full,
  output logic                stack_empty,
  output logic                ovf_err,
  output logic                unf_err
);

  typedef enum logic [2:0] {
    OP_SEQ    = 3'b000,
    OP_JUMP   = 3'b001,
    OP_BRANCH = 3'b010,
    OP_CALL   = 3'b011,
    OP_RET    = 3'b100
  } op_e;

  // Stack index width; depth itself needs one extra bit to represent "full".
  localparam int AW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [PC_WIDTH-1:0] STEP_V  = PC_WIDTH'(STEP);
  localparam logic [PC_WIDTH-1:0] RESET_V = PC_WIDTH'(RESET_VECTOR);
  localparam logic [DW-1:0]       FULL_V  = DW'(STACK_DEPTH);

  logic [PC_WIDTH-1:0] r_pc;
  logic [DW-1:0]       r_depth;
  logic                r_ovf_err;
  logic                r_unf_err;
  logic [PC_WIDTH-1:0] r_stack [STACK_DEPTH];

  logic [PC_WIDTH-1:0] w_seq_pc;
  logic [DW-1:0]       w_depth_dec;
  logic [AW-1:0]       w_push_idx;
  logic [AW-1:0]       w_pop_idx;
  logic                w_full;
  logic                w_empty;

  assign w_seq_pc    = r_pc + STEP_V;
  assign w_depth_dec = r_depth - DW'(1);
  assign w_push_idx  = r_depth[AW-1:0];
  assign w_pop_idx   = w_depth_dec[AW-1:0];
  assign w_full      = (r_depth == FULL_V);
  assign w_empty     = (r_depth == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc      <= RESET_V;
      r_depth   <= '0;
      r_ovf_err <= 1'b0;
      r_unf_err <= 1'b0;
    end else if (en) begin
      case (op_e'(op))
        OP_JUMP:   r_pc <= target;
        OP_BRANCH: r_pc <= cond ? (r_pc + offset) : w_seq_pc;
        OP_CALL: begin
          // The jump is taken even when the return address cannot be saved.
          r_pc <= target;
          if (w_full) begin
            r_ovf_err <= 1'b1;
          end else begin
            r_stack[w_push_idx] <= w_seq_pc;
            r_depth             <= r_depth + DW'(1);
          end
        end
        OP_RET: begin
          if (w_empty) begin
            r_pc      <= w_seq_pc;
            r_unf_err <= 1'b1;
          end else begin
            r_pc    <= r_stack[w_pop_idx];
            r_depth <= w_depth_dec;
          end
        end
        default:   r_pc <= w_seq_pc;
      endcase
    end
  end

  assign pc          = r_pc;
  assign depth       = r_depth;
  assign stack_full  = w_full;
  assign stack_empty = w_empty;
  assign ovf_err     = r_ovf_err;
  assign unf_err     = r_unf_err;

endmodule
